// File: rtl/uart_mem_tester.sv
// Byte-command memory tester between uart_rx and uart_tx: addressed write/read,
// whole-array fill and pipelined whole-array verify over a DATA_W x 2**ADDR_W RAM.
//
// state  | meaning
// IDLE   | waiting for a command byte
// ARG    | collecting little-endian argument bytes
// EXEC   | single address load, word write or word read
// FILL   | writing the pattern to every address, one per cycle
// VERIFY | reading every address and comparing one cycle behind the counter
// REPLY  | shifting reply bytes out over the tx handshake
module uart_mem_tester #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       overrun
);
    localparam int NB    = (DATA_W + 7) / 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int ARG_W = (NB * 8 > 16) ? NB * 8 : 16;
    localparam int RB_W  = (NB * 8 > 24) ? NB * 8 : 24;

    localparam logic [7:0] CH_A = 8'h41;
    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_F = 8'h46;
    localparam logic [7:0] CH_V = 8'h56;
    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CH_Q = 8'h3F;

    typedef enum logic [2:0] {IDLE, ARG, EXEC, FILL, VERIFY, REPLY} state_t;

    state_t             state, state_nx;
    logic [7:0]         cmd;
    logic [ARG_W-1:0]   arg_buf;
    logic [1:0]         arg_cnt;
    logic [1:0]         arg_last;
    logic [ADDR_W-1:0]  ptr, cnt, cmp_addr;
    logic               cmp_valid;
    logic [RB_W-1:0]    reply_buf;
    logic [2:0]         reply_left;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  pattern;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic               accept;
    logic               has_args;
    logic               tx_fire;
    logic               mismatch;

    assign pattern  = arg_buf[DATA_W-1:0];
    assign has_args = (rx_data == CH_A) || (rx_data == CH_W) ||
                      (rx_data == CH_F) || (rx_data == CH_V);
    assign arg_last = (cmd == CH_A) ? 2'd1 : 2'(NB - 1);
    assign tx_fire  = tx_valid && tx_ready;
    assign mismatch = (rd_data != pattern);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (rx_valid) begin
                if (has_args)            state_nx = ARG;
                else if (rx_data == CH_R) state_nx = EXEC;
                else                     state_nx = REPLY;
            end
            ARG: if (rx_valid && arg_cnt == arg_last) begin
                if (cmd == CH_F)      state_nx = FILL;
                else if (cmd == CH_V) state_nx = VERIFY;
                else                  state_nx = EXEC;
            end
            EXEC:   state_nx = REPLY;
            FILL:   if (cnt == '1) state_nx = REPLY;
            VERIFY: if (cmp_valid && (mismatch || cmp_addr == '1)) state_nx = REPLY;
            REPLY:  if (tx_fire && reply_left == 3'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Writes are gated by resetn so an abort never lands one more word.
    always_comb begin
        busy     = (state != IDLE);
        accept   = (state == IDLE) || (state == ARG);
        mem_we   = 1'b0;
        mem_addr = ptr;
        case (state)
            EXEC:   mem_we = resetn && (cmd == CH_W);
            FILL: begin
                mem_addr = cnt;
                mem_we   = resetn;
            end
            VERIFY: mem_addr = cnt;
            default: ;
        endcase
    end

    // In IDLE the RAM reads mem[ptr] every cycle, so an 'R' finds its word ready in EXEC.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= pattern;
        rd_data <= mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr        <= '0;
            cnt        <= '0;
            cmp_addr   <= '0;
            cmp_valid  <= 1'b0;
            cmd        <= '0;
            arg_buf    <= '0;
            arg_cnt    <= '0;
            reply_buf  <= '0;
            reply_left <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            overrun    <= 1'b0;
        end else begin
            if (rx_valid && !accept) overrun <= 1'b1;
            case (state)
                IDLE: if (rx_valid) begin
                    cmd     <= rx_data;
                    arg_cnt <= '0;
                    if (!has_args && rx_data != CH_R) begin
                        reply_buf  <= RB_W'(CH_Q);
                        reply_left <= 3'd1;
                    end
                end
                ARG: if (rx_valid) begin
                    arg_buf[{arg_cnt, 3'b000} +: 8] <= rx_data;
                    arg_cnt   <= arg_cnt + 2'd1;
                    cnt       <= '0;
                    cmp_valid <= 1'b0;
                end
                EXEC: begin
                    if (cmd == CH_A) begin
                        ptr        <= arg_buf[ADDR_W-1:0];
                        reply_buf  <= RB_W'(CH_K);
                        reply_left <= 3'd1;
                    end else if (cmd == CH_W) begin
                        ptr        <= ptr + 1'b1;
                        reply_buf  <= RB_W'(CH_K);
                        reply_left <= 3'd1;
                    end else begin
                        ptr        <= ptr + 1'b1;
                        reply_buf  <= RB_W'(rd_data);
                        reply_left <= 3'(NB);
                    end
                end
                FILL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        reply_buf  <= RB_W'(CH_K);
                        reply_left <= 3'd1;
                    end
                end
                VERIFY: begin
                    cnt       <= cnt + 1'b1;
                    cmp_addr  <= cnt;
                    cmp_valid <= 1'b1;
                    if (cmp_valid && mismatch) begin
                        reply_buf  <= RB_W'({16'(cmp_addr), CH_E});
                        reply_left <= 3'd3;
                    end else if (cmp_valid && cmp_addr == '1) begin
                        reply_buf  <= RB_W'(CH_K);
                        reply_left <= 3'd1;
                    end
                end
                REPLY: begin
                    if (tx_fire) begin
                        tx_valid   <= 1'b0;
                        reply_buf  <= reply_buf >> 8;
                        reply_left <= reply_left - 3'd1;
                    end else if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= reply_buf[7:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mem_tester.sv
// Directed plus randomized command traffic for uart_mem_tester (12-bit words, 16 deep),
// checked against a word-level model of the memory and pointer.
module tb_uart_mem_tester;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int MASK   = 'hFFF;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int mdl_mem[DEPTH];
    int mdl_ptr  = 0;
    logic [7:0] snd_q[$];
    logic [7:0] exp_q[$];

    uart_mem_tester #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .resetn(resetn),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] exp);
        int i = 0;
        while (!tx_valid && i < 300) begin
            @(negedge clk);
            i++;
        end
        if (!tx_valid) check($sformatf("%s_timeout", tag), 32'(tx_valid), 32'd1);
        else begin
            check(tag, 32'(tx_data), 32'(exp));
            @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string tag);
        int i = 0;
        while (busy && i < 100) begin
            @(negedge clk);
            i++;
        end
        check($sformatf("%s_idle", tag), 32'(busy), 32'd0);
    endtask

    task automatic xact(input string tag);
        foreach (snd_q[i]) send_byte(snd_q[i]);
        foreach (exp_q[i]) recv_byte($sformatf("%s[%0d]", tag, i), exp_q[i]);
        wait_idle(tag);
        snd_q.delete();
        exp_q.delete();
    endtask

    task automatic cmd_a(input logic [15:0] a);
        snd_q.push_back(8'h41); snd_q.push_back(a[7:0]); snd_q.push_back(a[15:8]);
        exp_q.push_back(8'h4B);
        mdl_ptr = int'(a) % DEPTH;
        xact($sformatf("A_%0h", a));
    endtask

    task automatic cmd_w(input logic [15:0] w);
        snd_q.push_back(8'h57); snd_q.push_back(w[7:0]); snd_q.push_back(w[15:8]);
        exp_q.push_back(8'h4B);
        mdl_mem[mdl_ptr] = int'(w) & MASK;
        mdl_ptr = (mdl_ptr + 1) % DEPTH;
        xact($sformatf("W_%0h", w));
    endtask

    task automatic cmd_r();
        int v = mdl_mem[mdl_ptr];
        snd_q.push_back(8'h52);
        exp_q.push_back(v[7:0]); exp_q.push_back(v[15:8]);
        xact($sformatf("R_at_%0d", mdl_ptr));
        mdl_ptr = (mdl_ptr + 1) % DEPTH;
    endtask

    task automatic cmd_f(input logic [15:0] p);
        snd_q.push_back(8'h46); snd_q.push_back(p[7:0]); snd_q.push_back(p[15:8]);
        exp_q.push_back(8'h4B);
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = int'(p) & MASK;
        xact($sformatf("F_%0h", p));
    endtask

    task automatic cmd_v(input logic [15:0] p);
        int bad = -1;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (mdl_mem[i] != (int'(p) & MASK)) bad = i;
        snd_q.push_back(8'h56); snd_q.push_back(p[7:0]); snd_q.push_back(p[15:8]);
        if (bad < 0) exp_q.push_back(8'h4B);
        else begin
            exp_q.push_back(8'h45); exp_q.push_back(bad[7:0]); exp_q.push_back(8'h00);
        end
        xact($sformatf("V_%0h", p));
    endtask

    task automatic cmd_unk(input logic [7:0] b);
        snd_q.push_back(b);
        exp_q.push_back(8'h3F);
        xact($sformatf("unk_%0h", b));
    endtask

    initial begin
        logic [15:0] p0, pa, pb, cur_pat, w;
        logic [7:0]  b, d0;
        logic        stable, extra;
        int          v, sel;

        repeat (3) @(negedge clk);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_overrun",  32'(overrun),  32'd0);
        resetn = 1'b1;

        p0 = 16'($urandom_range(0, MASK));
        if (p0 == 16'h0A34 || p0 == 16'h0011) p0 = 16'h05C3;
        cmd_f(p0);
        cmd_v(p0);

        cmd_a(16'h0003);
        cmd_w(16'h0A34);
        cmd_a(16'h0003);
        cmd_r();
        cmd_r();

        cmd_a(16'h000F);
        cmd_w(16'h0011);
        cmd_r();
        cmd_a(16'h000F);
        cmd_r();

        cmd_f(16'h0FFF);
        cmd_v(16'h0FFF);
        cmd_a(16'h0009);
        cmd_w(16'h0000);
        cmd_v(16'h0FFF);

        cmd_unk(8'h5A);

        cur_pat = 16'h0FFF;
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: cmd_a(16'($urandom));
                1: cmd_w(16'($urandom));
                2: cmd_r();
                3: cmd_v(($urandom_range(0, 1) == 1) ? cur_pat : 16'($urandom));
                4: begin
                    cur_pat = 16'($urandom);
                    cmd_f(cur_pat);
                end
                default: begin
                    b = 8'($urandom);
                    if (b == 8'h41 || b == 8'h57 || b == 8'h52 || b == 8'h46 || b == 8'h56)
                        b = 8'h7E;
                    cmd_unk(b);
                end
            endcase
        end

        pa = 16'($urandom_range(0, MASK));
        send_byte(8'h46); send_byte(pa[7:0]); send_byte(pa[15:8]);
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = int'(pa) & MASK;
        repeat (3) @(negedge clk);
        send_byte(8'h52);
        recv_byte("fill_with_overrun", 8'h4B);
        check("overrun_set", 32'(overrun), 32'd1);
        extra = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid) extra = 1'b1;
        end
        check("no_reply_for_dropped", 32'(extra), 32'd0);
        wait_idle("fill_with_overrun");

        w = 16'($urandom);
        cmd_a(16'($urandom_range(0, DEPTH - 1)));
        cmd_w(w);
        cmd_a(16'(mdl_ptr + DEPTH - 1));
        v = mdl_mem[mdl_ptr];
        mdl_ptr = (mdl_ptr + 1) % DEPTH;
        tx_ready = 1'b0;
        send_byte(8'h52);
        for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
        d0 = tx_data;
        stable = tx_valid;
        repeat (50) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== d0) stable = 1'b0;
        end
        check("held_reply_stable", 32'(stable), 32'd1);
        tx_ready = 1'b1;
        recv_byte("held_r[0]", v[7:0]);
        recv_byte("held_r[1]", v[15:8]);
        wait_idle("held_r");

        pb = 16'(int'(pa) ^ 'h5A5);
        send_byte(8'h46); send_byte(pb[7:0]); send_byte(pb[15:8]);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_tx_valid", 32'(tx_valid), 32'd0);
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_overrun",  32'(overrun),  32'd0);
        resetn = 1'b1;
        mdl_mem[0] = int'(pb) & MASK;
        mdl_ptr = 0;
        cmd_r();
        cmd_a(16'h000F);
        cmd_r();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed hang expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_mem_tester.md
Name: uart_mem_tester

Overview:
- Byte-command engine that exercises an on-chip memory of DATA_W x 2**ADDR_W over a UART byte stream.
- Sits between the existing uart_rx (byte + valid pulse) and uart_tx (byte + handshake) blocks.
- Replaces the single-bit echo test with a configurable width/depth memory tester: addressed write/read, whole-array fill and whole-array verify.
- Used to stress block-RAM cascading at arbitrary geometries.

Parameters:
- DATA_W, 8: memory word width, 1..32. NB = ceil(DATA_W/8) bytes per word on the wire.
- ADDR_W, 16: address width, 1..16. DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- rx_data  in  8  received byte, valid only while rx_valid=1
- rx_valid  in  1  one-cycle pulse per received byte
- tx_data  out  8  byte to send
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts; a transfer occurs on a cycle with tx_valid && tx_ready
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; set when rx_valid arrives while not accepting bytes

Behaviour:
- Reset values:
  - tx_valid=0, tx_data=0, busy=0, overrun=0.
  - Address pointer ptr=0, FSM=IDLE.
  - Memory contents are not cleared by reset.
- Memory:
  - Single-port, synchronous read, 1-cycle latency.
  - Written with the low DATA_W bits of the assembled word.
  - Read words are zero-extended to NB*8 bits.
- Multi-byte fields are little-endian.
- An address field is always 2 bytes; bits above ADDR_W are ignored.
- Commands (first byte, ASCII):
  - 'A' + 2 bytes: ptr <= addr. Reply 'K'.
  - 'W' + NB bytes: mem[ptr] <= word; ptr <= ptr+1 (wraps DEPTH-1 -> 0). Reply 'K'.
  - 'R': reply NB bytes of mem[ptr]; ptr <= ptr+1 (wraps).
  - 'F' + NB bytes: write the pattern to every address 0..DEPTH-1, one per cycle (DEPTH cycles). Reply 'K'. ptr unchanged.
  - 'V' + NB bytes: read every address 0..DEPTH-1, pipelined one per cycle, and compare against the pattern. Stop at the first mismatch.
    - All match: reply 'K'.
    - Mismatch: reply 'E' followed by 2 bytes of the first failing address, zero-extended.
    - ptr unchanged.
  - Any other byte: reply '?'. No state change.
- FSM states: IDLE, ARG (collect argument bytes with a byte counter), EXEC (single write/read issue), FILL, VERIFY, REPLY (shift out 1..3 reply bytes).
  - IDLE -> ARG on a command byte that takes arguments.
  - IDLE -> EXEC for 'R'; IDLE -> REPLY for unknown bytes.
  - ARG -> EXEC, FILL or VERIFY after the last argument byte.
  - FILL and VERIFY -> REPLY when done.
  - REPLY -> IDLE after the last byte transfers.
- Byte acceptance:
  - Bytes are accepted only in IDLE and ARG.
  - rx_valid in any other state is dropped and sets overrun. overrun clears only on reset.
  - There is no timeout in ARG; the command completes on the next arg byte.
- TX handshake:
  - tx_valid is raised with stable tx_data and held until tx_ready.
  - The next reply byte is presented on the cycle after a transfer (at most one byte per 2 cycles).
- Latency: from the last rx byte of a 'W' or 'A' command, tx_valid asserts by cycle +3.
- Verify pipeline: the address counter runs 1 cycle ahead of the comparison. The failing address reported is the address of the compared word, not the counter value.
- Reset mid-operation (including FILL, VERIFY, REPLY):
  - Aborts immediately; tx_valid drops on the next edge.
  - No further memory writes.
  - Partially filled memory stays partially filled.

Test Plan:
- DATA_W=12, ADDR_W=4. Send 'A',0x03,0x00 then 'W',0x34,0x0A -> 'K','K'. Then 'A',0x03,0x00,'R' -> reply 0x34,0x0A. ptr=4 afterwards.
- ptr wrap: 'A',0x0F,0x00; 'W',0x11,0x00; 'R' -> the read returns mem[0], not mem[15]. A second 'A',0x0F,0x00,'R' -> 0x11,0x00.
- 'F',0xFF,0x0F then 'V',0xFF,0x0F -> 'K','K'. Then 'A',0x09,0x00; 'W',0x00,0x00; 'V',0xFF,0x0F -> 'K','K','E',0x09,0x00.
- Unknown byte 'Z' -> '?'. A byte pulsed during FILL -> overrun=1, no reply for it, and the FILL still ends in 'K'.
- Hold tx_ready=0 for 50 cycles during an 'R' reply -> tx_valid and tx_data are stable throughout. Both bytes are delivered in order once tx_ready=1.
- Assert resetn=0 for 1 cycle midway through FILL -> tx_valid=0, busy=0, overrun=0. The next 'R' at ptr 0 returns the pattern; an address past the abort point returns the old contents.
